// File: rtl/synth_voice_controller.sv
// synth_voice_controller: button-to-channel control with a tempo-timed demo sequencer.
// Define SYNTH_DEMO_LOOP_EN to repeat the demo song until aborted.
module synth_voice_controller #(
  parameter int NUM_CHANNELS = 4,
  parameter int PITCH_W      = 12,
  parameter int SONG_DEPTH   = 32,
  parameter int DUR_W        = 4,
  parameter int TICK_DIV     = 6250000,
  parameter int BASE_PITCH   = 212,
  localparam int ADDR_W      = $clog2(SONG_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CHANNELS-1:0]         btn_keys,
  input  logic                            btn_wave,
  input  logic                            btn_mode,
  input  logic                            wr_en,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [PITCH_W+DUR_W-1:0]        wr_data,
  input  logic [ADDR_W:0]                 song_len,
  output logic [NUM_CHANNELS-1:0]         channel_ena,
  output logic [NUM_CHANNELS*PITCH_W-1:0] pitches,
  output logic [NUM_CHANNELS*2-1:0]       waveforms,
  output logic                            demo_active,
  output logic [ADDR_W-1:0]               step_addr
);

  localparam int TICK_W = $clog2(TICK_DIV);

  typedef enum logic [1:0] {PLAY, FETCH, NOTE, GAP} state_t;

  state_t state, state_nxt;

  logic [NUM_CHANNELS-1:0] keys_q;
  logic                    wave_q;
  logic                    mode_q;
  logic [NUM_CHANNELS-1:0] key_edge;
  logic                    wave_edge;
  logic                    mode_edge;
  logic                    abort;

  logic [1:0]              wave_type;
  logic [1:0]              wave_nxt;

  logic [ADDR_W-1:0]       step;
  logic [ADDR_W-1:0]       step_nxt;
  logic [ADDR_W:0]         step_inc;

  logic [PITCH_W+DUR_W-1:0] mem [SONG_DEPTH];
  logic [PITCH_W+DUR_W-1:0] rd_data;
  logic [PITCH_W-1:0]       rd_pitch;
  logic [PITCH_W-1:0]       pitch_q;
  logic [DUR_W-1:0]         dur_q;
  logic [PITCH_W-1:0]       cur_pitch;

  logic [TICK_W-1:0]       tick_cnt;
  logic                    tick_done;
  logic [DUR_W-1:0]        dur_cnt;
  logic [DUR_W-1:0]        dur_last_val;
  logic                    dur_last;

  logic [NUM_CHANNELS-1:0]         ena_d;
  logic [NUM_CHANNELS*PITCH_W-1:0] pitches_d;

  assign key_edge  = btn_keys & ~keys_q;
  assign wave_edge = btn_wave & ~wave_q;
  assign mode_edge = btn_mode & ~mode_q;
  assign abort     = mode_edge | (|key_edge);
  assign wave_nxt  = wave_type + {1'b0, wave_edge};

  assign step_inc     = {1'b0, step} + (ADDR_W+1)'(1);
  assign step_addr    = step;
  assign rd_pitch     = rd_data[PITCH_W+DUR_W-1:DUR_W];
  assign tick_done    = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign dur_last_val = (dur_q == '0) ? '0 : dur_q - DUR_W'(1);
  assign dur_last     = (dur_cnt == dur_last_val);
  // On the FETCH->NOTE edge the note is still in rd_data, not yet latched.
  assign cur_pitch    = (state == FETCH) ? rd_pitch : pitch_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PLAY;
      step      <= '0;
      keys_q    <= '0;
      wave_q    <= 1'b0;
      mode_q    <= 1'b0;
      wave_type <= 2'd0;
    end else begin
      state     <= state_nxt;
      step      <= step_nxt;
      keys_q    <= btn_keys;
      wave_q    <= btn_wave;
      mode_q    <= btn_mode;
      wave_type <= wave_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    unique case (state)
      PLAY: begin
        if (mode_edge && song_len != '0) begin
          state_nxt = FETCH;
          step_nxt  = '0;
        end
      end
      FETCH: state_nxt = NOTE;
      NOTE: begin
        if (tick_done && dur_last) state_nxt = GAP;
      end
      GAP: begin
        if (tick_done) begin
          if (step_inc >= song_len) begin
`ifdef SYNTH_DEMO_LOOP_EN
            state_nxt = (song_len != '0) ? FETCH : PLAY;
`else
            state_nxt = PLAY;
`endif
            step_nxt  = '0;
          end else begin
            state_nxt = FETCH;
            step_nxt  = step_inc[ADDR_W-1:0];
          end
        end
      end
      default: state_nxt = PLAY;
    endcase
    if (state != PLAY && abort) begin
      state_nxt = PLAY;
      step_nxt  = '0;
    end
  end

  // Read address follows the next step so data is ready during FETCH.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[step_nxt];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pitch_q <= '0;
      dur_q   <= '0;
    end else if (state == FETCH) begin
      pitch_q <= rd_pitch;
      dur_q   <= rd_data[DUR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      dur_cnt  <= '0;
    end else if (state_nxt != state) begin
      tick_cnt <= '0;
      dur_cnt  <= '0;
    end else if (state == NOTE || state == GAP) begin
      tick_cnt <= tick_done ? '0 : tick_cnt + TICK_W'(1);
      if (tick_done) dur_cnt <= dur_cnt + DUR_W'(1);
    end
  end

  always_comb begin
    ena_d     = '0;
    pitches_d = '0;
    unique case (1'b1)
      (state_nxt == PLAY): begin
        ena_d = btn_keys;
        for (int i = 0; i < NUM_CHANNELS; i++)
          pitches_d[i*PITCH_W +: PITCH_W] = PITCH_W'(BASE_PITCH >> i);
      end
      (state_nxt == NOTE): begin
        ena_d[0]              = (cur_pitch != '0);
        pitches_d[PITCH_W-1:0] = cur_pitch;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      channel_ena <= '0;
      pitches     <= '0;
      waveforms   <= '0;
      demo_active <= 1'b0;
    end else begin
      channel_ena <= ena_d;
      pitches     <= pitches_d;
      waveforms   <= {NUM_CHANNELS{wave_nxt}};
      demo_active <= (state_nxt != PLAY);
    end
  end

endmodule

// File: tb/tb_synth_voice_controller.sv
// Bench for synth_voice_controller: PLAY vectors, random PLAY, demo traces.
// Expected demo traces are expanded from the song contents and timing rules.
module tb_synth_voice_controller;

  localparam int NCH = 4;
  localparam int PW  = 12;
  localparam int DW  = 4;
  localparam int T   = 4;
`ifdef SYNTH_DEMO_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic            clk = 0;
  logic            rst;
  logic [NCH-1:0]  btn_keys;
  logic            btn_wave;
  logic            btn_mode;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [PW+DW-1:0] wr_data;
  logic [5:0]      song_len;
  logic [NCH-1:0]  channel_ena;
  logic [NCH*PW-1:0] pitches;
  logic [NCH*2-1:0]  waveforms;
  logic            demo_active;
  logic [4:0]      step_addr;

  synth_voice_controller #(
    .NUM_CHANNELS(NCH), .PITCH_W(PW), .SONG_DEPTH(32),
    .DUR_W(DW), .TICK_DIV(T), .BASE_PITCH(212)
  ) dut (
    .clk(clk), .rst(rst), .btn_keys(btn_keys), .btn_wave(btn_wave),
    .btn_mode(btn_mode), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .song_len(song_len), .channel_ena(channel_ena),
    .pitches(pitches), .waveforms(waveforms), .demo_active(demo_active),
    .step_addr(step_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0]    ena;
    logic [NCH*PW-1:0] pit;
    logic              demo;
    logic [4:0]        step;
  } exp_t;

  typedef struct {
    logic [NCH-1:0] keys;
    logic           wave;
    logic [NCH-1:0] exp_ena;
    logic [7:0]     exp_wf;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [1:0]  wcount   = 0;
  logic        wprev    = 0;
  logic [NCH*PW-1:0] pbase;
  logic [PW+DW-1:0]  smem [32];
  exp_t        q[$];
  vec_t        tbl[12];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [NCH-1:0] e_ena,
                         input logic [NCH*PW-1:0] e_pit, input logic e_demo,
                         input logic [4:0] e_step);
    check({nm, "_ena"}, 64'(channel_ena), 64'(e_ena));
    check({nm, "_pitch"}, 64'(pitches), 64'(e_pit));
    check({nm, "_wave"}, 64'(waveforms), 64'({NCH{wcount}}));
    check({nm, "_demo"}, 64'(demo_active), 64'(e_demo));
    check({nm, "_step"}, 64'(step_addr), 64'(e_step));
  endtask

  task automatic wr(input int a, input logic [PW+DW-1:0] d);
    wr_en = 1; wr_addr = 5'(a); wr_data = d;
    smem[a] = d;
    @(posedge clk); #1;
    wr_en = 0;
  endtask

  task automatic push(input logic [NCH-1:0] ena, input logic [NCH*PW-1:0] pit,
                      input logic demo, input int step, input int n);
    exp_t e;
    e.ena = ena; e.pit = pit; e.demo = demo; e.step = 5'(step);
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  // One entry: fetch cycle, note of max(dur,1) ticks, one-tick gap.
  task automatic build(input int len);
    logic [PW-1:0] p;
    int nd;
    q.delete();
    for (int r = 0; r < (LOOP ? 2 : 1); r++)
      for (int k = 0; k < len; k++) begin
        p  = smem[k][PW+DW-1:DW];
        nd = (smem[k][DW-1:0] == 0) ? 1 : int'(smem[k][DW-1:0]);
        push('0, '0, 1, k, 1);
        push({3'b0, p != 0}, {36'b0, p}, 1, k, nd * T);
        push('0, '0, 1, k, T);
      end
    if (!LOOP) push('0, pbase, 0, 0, 2);
  endtask

  task automatic run_trace(input int abort_at, input int kind,
                           input int shrink_at, input logic [5:0] shrink_len);
    exp_t e;
    if (LOOP && abort_at < 0) begin
      abort_at = q.size() - 1;
      kind = 2;
    end
    btn_mode = 1; @(posedge clk); #1; btn_mode = 0;
    for (int i = 0; i < q.size(); i++) begin
      e = q[i];
      chk_out("trace", e.ena, e.pit, e.demo, e.step);
      if (i == shrink_at) song_len = shrink_len;
      if (i == abort_at) begin
        btn_keys = (kind == 2) ? 4'b0000 : (kind == 3) ? 4'b0100 : 4'b0010;
        btn_mode = (kind >= 2);
        @(posedge clk); #1;
        chk_out("abort", btn_keys, pbase, 0, 0);
        btn_keys = 0; btn_mode = 0;
        @(posedge clk); #1;
        chk_out("post_abort", '0, pbase, 0, 0);
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int len, dl, kind, ab;
    logic [31:0] r;
    logic [PW-1:0] p;
    for (int i = 0; i < NCH; i++) pbase[i*PW +: PW] = PW'(212 >> i);

    tbl[0]  = '{4'b0100, 1'b0, 4'b0100, 8'h00};
    tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 8'h55};
    tbl[2]  = '{4'b0000, 1'b0, 4'b0000, 8'h55};
    tbl[3]  = '{4'b0011, 1'b1, 4'b0011, 8'hAA};
    tbl[4]  = '{4'b0011, 1'b0, 4'b0011, 8'hAA};
    tbl[5]  = '{4'b1000, 1'b1, 4'b1000, 8'hFF};
    tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 8'hFF};
    tbl[7]  = '{4'b0000, 1'b0, 4'b0000, 8'hFF};
    tbl[8]  = '{4'b1111, 1'b1, 4'b1111, 8'h00};
    tbl[9]  = '{4'b0000, 1'b0, 4'b0000, 8'h00};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 8'h55};
    tbl[11] = '{4'b0000, 1'b0, 4'b0000, 8'h55};

    rst = 1; btn_keys = 0; btn_wave = 0; btn_mode = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0; song_len = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", '0, '0, 0, 0);
    rst = 0;
    @(posedge clk); #1;
    chk_out("idle", '0, pbase, 0, 0);

    for (int i = 0; i < 12; i++) begin
      btn_keys = tbl[i].keys; btn_wave = tbl[i].wave;
      @(posedge clk); #1;
      check($sformatf("vec%0d_ena", i), 64'(channel_ena), 64'(tbl[i].exp_ena));
      check($sformatf("vec%0d_wave", i), 64'(waveforms), 64'(tbl[i].exp_wf));
      check($sformatf("vec%0d_pitch", i), 64'(pitches), 64'(pbase));
    end
    wcount = tbl[11].exp_wf[1:0];
    wprev  = tbl[11].wave;

    for (int n = 0; n < 100; n++) begin
      r = $urandom;
      btn_keys = r[3:0]; btn_wave = r[4];
      if (r[4] && !wprev) wcount = wcount + 2'd1;
      wprev = r[4];
      @(posedge clk); #1;
      chk_out("rand_play", r[3:0], pbase, 0, 0);
    end
    btn_keys = 0; btn_wave = 0; wprev = 0;
    @(posedge clk); #1;

    wr(0, {12'd212, 4'd2});
    wr(1, {12'd0, 4'd1});
    wr(2, {12'd106, 4'd1});
    song_len = 3;
    build(3);
    run_trace(-1, 0, -1, 0);

    song_len = 0;
    btn_mode = 1; @(posedge clk); #1;
    chk_out("len0_mode", '0, pbase, 0, 0);
    btn_mode = 0; @(posedge clk); #1;
    chk_out("len0_idle", '0, pbase, 0, 0);

    song_len = 3;
    build(3);
    run_trace(4, 1, -1, 0);
    run_trace(10, 3, -1, 0);
    run_trace(12, 2, -1, 0);

    build(1);
    run_trace(-1, 0, 2, 1);
    song_len = 3;
    @(posedge clk); #1;

    btn_mode = 1; @(posedge clk); #1; btn_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_demo", 64'(demo_active), 64'(1));
    rst = 1; @(posedge clk); #1;
    wcount = 0;
    chk_out("mid_rst", '0, '0, 0, 0);
    rst = 0; @(posedge clk); #1;
    chk_out("after_rst", '0, pbase, 0, 0);
    build(3);
    run_trace(-1, 0, -1, 0);

    for (int it = 0; it < 8; it++) begin
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        p = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
        wr(k, {p, 4'($urandom_range(0, 3))});
      end
      song_len = 6'(len);
      @(posedge clk); #1;
      build(len);
      dl = LOOP ? q.size() : q.size() - 2;
      kind = $urandom_range(0, 3);
      ab = (kind == 0) ? -1 : $urandom_range(0, dl - 1);
      run_trace(ab, kind, -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
